dm_access_ctrl: RTL and testbench

- Sits in the MEM stage, directly downstream of the MEM-stage byte-enable/load-op decoder.
- Consumes the decoder's byte enables and load op and drives a multi-cycle req/ack data-memory bus.
- Stalls the pipeline until the access completes, then hands sign- or zero-extended load data to WB through a result register.
- Also flags misaligned accesses and bus timeouts.

---
 rtl/dm_access_ctrl_if.sv | 31 +++
 rtl/dm_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl_if
// Multi-cycle req/ack data-memory bus between the MEM-stage access controller
// (master) and the data memory or bus fabric (slave).
//   bus_req    master->slave  request, held until bus_ack
//   bus_we     master->slave  write request
//   bus_addr   master->slave  word-aligned address
//   bus_byteen master->slave  byte-lane enables
//   bus_wdata  master->slave  lane-aligned store data
//   bus_ack    slave->master  single-cycle completion strobe
//   bus_rdata  slave->master  read data, valid with bus_ack
// -----------------------------------------------------------------------------
interface dm_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_byteen, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// MEM-stage data-memory access controller. Takes the decoded byte enables and
// load op of the MEM-stage instruction, runs one req/ack bus transaction,
// stalls the pipeline until it completes and hands extended load data to WB.
// Misaligned accesses are flagged and never reach the bus; a transaction with
// no ack within TIMEOUT_CYC wait cycles is abandoned and reported.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   m_valid       MEM-stage instruction valid
//   m_load        instruction is a load
//   m_addr        effective address
//   m_wdata       store data, unshifted
//   m_byteen      store byte enables (0 for loads)
//   m_loadop      load op: 0001 lb, 0010 lh, 0011 lbu, 0100 lhu, else word
//   stall_m       hold IF/ID/EX/MEM this cycle
//   m_adel        load address misaligned (combinational)
//   m_ades        store address misaligned (combinational)
//   bus           data-memory bus, master side
//   w_rdata       extended load data for WB
//   w_load_valid  one-cycle pulse: w_rdata updated by a load
//   w_buserr      one-cycle pulse: access timed out
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m_valid,
    input  logic                   m_load,
    input  logic [31:0]            m_addr,
    input  logic [31:0]            m_wdata,
    input  logic [3:0]             m_byteen,
    input  logic [3:0]             m_loadop,
    output logic                   stall_m,
    output logic                   m_adel,
    output logic                   m_ades,
    dm_access_ctrl_if.master       bus,
    output logic [31:0]            w_rdata,
    output logic                   w_load_valid,
    output logic                   w_buserr
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [3:0]  loadop_lat;
    logic [1:0]  addr_lo_lat;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        access;
    logic        in_wait;
    logic        timeout;
    logic [3:0]  load_byteen;
    logic [4:0]  lane_shift;

    // Load size decode; any unlisted code behaves as a word load.
    assign is_byte = (m_loadop == 4'b0001) || (m_loadop == 4'b0011);
    assign is_half = (m_loadop == 4'b0010) || (m_loadop == 4'b0100);
    assign is_word = !is_byte && !is_half;

    assign m_adel = m_valid && m_load &&
                    ((is_word && (m_addr[1:0] != 2'b00)) || (is_half && m_addr[0]));

    assign m_ades = m_valid && !m_load &&
                    (((m_byteen == 4'b1111) && (m_addr[1:0] != 2'b00)) ||
                     (((m_byteen == 4'b0011) || (m_byteen == 4'b1100)) && m_addr[0]));

    assign access  = m_valid && (m_load || (m_byteen != 4'b0000)) && !m_adel && !m_ades;
    assign in_wait = (state == WAIT);
    assign timeout = in_wait && !bus.bus_ack && (wait_cnt == TO_LAST);

    // Released in the completing cycle so the pipeline advances on the same
    // edge that returns the FSM to IDLE; the access is never re-issued.
    assign stall_m = access && !(in_wait && (bus.bus_ack || timeout));

    assign lane_shift = {m_addr[1:0], 3'b000};

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        load_byteen = 4'b1111;
        if (is_byte) begin
            load_byteen = 4'b0001 << m_addr[1:0];
        end else if (is_half) begin
            load_byteen = 4'b0011 << m_addr[1:0];
        end
    end

    // Move the addressed lane down to bit 0, then extend from bit 7 or 15.
    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [1:0]  addr_lo,
                                                input logic [3:0]  op);
        logic [31:0] lane;
        lane = rdata >> {addr_lo, 3'b000};
        case (op)
            4'b0001: extend_load = {{24{lane[7]}}, lane[7:0]};
            4'b0010: extend_load = {{16{lane[15]}}, lane[15:0]};
            4'b0011: extend_load = {24'h0, lane[7:0]};
            4'b0100: extend_load = {16'h0, lane[15:0]};
            default: extend_load = lane;
        endcase
    endfunction

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            loadop_lat     <= '0;
            addr_lo_lat    <= '0;
            bus.bus_req    <= 1'b0;
            bus.bus_we     <= 1'b0;
            bus.bus_addr   <= '0;
            bus.bus_byteen <= '0;
            bus.bus_wdata  <= '0;
            w_rdata        <= '0;
            w_load_valid   <= 1'b0;
            w_buserr       <= 1'b0;
        end else begin
            w_load_valid <= 1'b0;
            w_buserr     <= 1'b0;

            case (state)
                IDLE: begin
                    // An ack seen here belongs to no transaction and is ignored.
                    if (access) begin
                        bus.bus_req    <= 1'b1;
                        bus.bus_we     <= !m_load;
                        bus.bus_addr   <= {m_addr[31:2], 2'b00};
                        bus.bus_byteen <= m_load ? load_byteen : m_byteen;
                        bus.bus_wdata  <= m_wdata << lane_shift;
                        loadop_lat     <= m_loadop;
                        addr_lo_lat    <= m_addr[1:0];
                        wait_cnt       <= '0;
                        state          <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            w_rdata      <= extend_load(bus.bus_rdata, addr_lo_lat, loadop_lat);
                            w_load_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (timeout) begin
                        bus.bus_req <= 1'b0;
                        w_rdata     <= '0;
                        w_buserr    <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
// Directed bench for dm_access_ctrl with TIMEOUT_CYC = 4. Inputs are driven
// 1 ns after the rising edge and outputs are sampled in the same window.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic        m_load;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic [3:0]  m_loadop;
    logic        stall_m;
    logic        m_adel;
    logic        m_ades;
    logic [31:0] w_rdata;
    logic        w_load_valid;
    logic        w_buserr;

    int checks = 0;
    int errors = 0;

    dm_access_ctrl_if bus_if ();

    dm_access_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_valid      (m_valid),
        .m_load       (m_load),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_byteen     (m_byteen),
        .m_loadop     (m_loadop),
        .stall_m      (stall_m),
        .m_adel       (m_adel),
        .m_ades       (m_ades),
        .bus          (bus_if.master),
        .w_rdata      (w_rdata),
        .w_load_valid (w_load_valid),
        .w_buserr     (w_buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid  = 1'b0;
        m_load   = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_byteen = '0;
        m_loadop = '0;
    endtask

    // Issues one access, acks it after n_wait quiet wait cycles (n_wait >= 1)
    // and returns with the completing edge just past. Reports stall cycles and
    // the bus fields seen in the first wait cycle.
    task automatic do_access(input logic        load,
                             input logic [31:0] addr,
                             input logic [31:0] wdata,
                             input logic [3:0]  byteen,
                             input logic [3:0]  loadop,
                             input int          n_wait,
                             input logic [31:0] rdata,
                             output int          stalls,
                             output logic        seen_we,
                             output logic [31:0] seen_addr,
                             output logic [3:0]  seen_byteen,
                             output logic [31:0] seen_wdata);
        m_valid  = 1'b1;
        m_load   = load;
        m_addr   = addr;
        m_wdata  = wdata;
        m_byteen = byteen;
        m_loadop = loadop;
        #1;
        stalls = int'(stall_m);
        for (int i = 0; i < n_wait; i++) begin
            step();
            stalls += int'(stall_m);
            if (i == 0) begin
                seen_we     = bus_if.bus_we;
                seen_addr   = bus_if.bus_addr;
                seen_byteen = bus_if.bus_byteen;
                seen_wdata  = bus_if.bus_wdata;
            end
        end
        step();
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdata;
        #1;
        stalls += int'(stall_m);
        step();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        idle_inputs();
        #1;
    endtask

    int          stalls;
    int          req_cycles;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_byteen;
    logic [31:0] s_wdata;

    initial begin
        reset            = 1'b0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        idle_inputs();
        step();
        step();

        // Reset state
        check("rst_bus_req", 32'(bus_if.bus_req), 32'h0);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_w_rdata", w_rdata, 32'h0);
        check("rst_w_load_valid", 32'(w_load_valid), 32'h0);
        check("rst_stall", 32'(stall_m), 32'h0);

        #2 reset = 1'b1;
        step();

        // lb at 0x1003, ack in the fourth wait cycle (also the last cycle
        // before the timeout count would expire; ack must win)
        do_access(1'b1, 32'h0000_1003, 32'h0, 4'b0000, 4'b0001, 3, 32'h80FF_1234,
                  stalls, s_we, s_addr, s_byteen, s_wdata);
        check("lb_stall_cycles", 32'(stalls), 32'd4);
        check("lb_bus_we", 32'(s_we), 32'h0);
        check("lb_bus_addr", s_addr, 32'h0000_1000);
        check("lb_bus_byteen", 32'(s_byteen), 32'h8);
        check("lb_w_rdata", w_rdata, 32'hFFFF_FF80);
        check("lb_w_load_valid", 32'(w_load_valid), 32'h1);
        check("lb_buserr", 32'(w_buserr), 32'h0);
        check("lb_req_dropped", 32'(bus_if.bus_req), 32'h0);
        step();
        check("lb_pulse_one_cycle", 32'(w_load_valid), 32'h0);

        // lhu / lh at 0x2002, minimum latency
        do_access(1'b1, 32'h0000_2002, 32'h0, 4'b0000, 4'b0100, 1, 32'hBEEF_0000,
                  stalls, s_we, s_addr, s_byteen, s_wdata);
        check("lhu_stall_cycles", 32'(stalls), 32'd2);
        check("lhu_bus_byteen", 32'(s_byteen), 32'hC);
        check("lhu_w_rdata", w_rdata, 32'h0000_BEEF);
        step();
        do_access(1'b1, 32'h0000_2002, 32'h0, 4'b0000, 4'b0010, 1, 32'hBEEF_0000,
                  stalls, s_we, s_addr, s_byteen, s_wdata);
        check("lh_w_rdata", w_rdata, 32'hFFFF_BEEF);
        check("lh_w_load_valid", 32'(w_load_valid), 32'h1);
        step();

        // sb at 0x12 with decoder byte enables 0100
        do_access(1'b0, 32'h0000_0012, 32'h0000_00AB, 4'b0100, 4'b0000, 2, 32'hDEAD_BEEF,
                  stalls, s_we, s_addr, s_byteen, s_wdata);
        check("sb_stall_cycles", 32'(stalls), 32'd3);
        check("sb_bus_we", 32'(s_we), 32'h1);
        check("sb_bus_addr", s_addr, 32'h0000_0010);
        check("sb_bus_byteen", 32'(s_byteen), 32'h4);
        check("sb_bus_wdata", s_wdata, 32'h00AB_0000);
        check("sb_no_load_valid", 32'(w_load_valid), 32'h0);
        check("sb_w_rdata_held", w_rdata, 32'hFFFF_BEEF);
        step();

        // Misaligned lw at 0x5
        m_valid  = 1'b1;
        m_load   = 1'b1;
        m_addr   = 32'h0000_0005;
        m_loadop = 4'b0000;
        #1;
        check("lw_mis_adel", 32'(m_adel), 32'h1);
        check("lw_mis_ades", 32'(m_ades), 32'h0);
        check("lw_mis_stall", 32'(stall_m), 32'h0);
        step();
        check("lw_mis_no_req", 32'(bus_if.bus_req), 32'h0);

        // Misaligned sh at 0x3
        m_load   = 1'b0;
        m_addr   = 32'h0000_0003;
        m_byteen = 4'b1100;
        m_wdata  = 32'h0000_1234;
        #1;
        check("sh_mis_ades", 32'(m_ades), 32'h1);
        check("sh_mis_adel", 32'(m_adel), 32'h0);
        check("sh_mis_stall", 32'(stall_m), 32'h0);
        step();
        check("sh_mis_no_req", 32'(bus_if.bus_req), 32'h0);

        // Misaligned sw at 0x2 and aligned lhu at 0x2
        m_addr   = 32'h0000_0002;
        m_byteen = 4'b1111;
        #1;
        check("sw_mis_ades", 32'(m_ades), 32'h1);
        m_load   = 1'b1;
        m_byteen = 4'b0000;
        m_loadop = 4'b0100;
        #1;
        check("lhu_al_adel", 32'(m_adel), 32'h0);
        idle_inputs();
        #1;
        step();

        // Timeout: lw at 0x40, never acked
        m_valid  = 1'b1;
        m_load   = 1'b1;
        m_addr   = 32'h0000_0040;
        m_loadop = 4'b0000;
        #1;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            req_cycles += int'(bus_if.bus_req);
            if (i == 2) check("to_stall_before_last", 32'(stall_m), 32'h1);
            if (i == 3) check("to_stall_released", 32'(stall_m), 32'h0);
        end
        step();
        idle_inputs();
        #1;
        check("to_req_cycles", 32'(req_cycles), 32'd4);
        check("to_buserr", 32'(w_buserr), 32'h1);
        check("to_w_rdata", w_rdata, 32'h0);
        check("to_req_dropped", 32'(bus_if.bus_req), 32'h0);
        check("to_no_load_valid", 32'(w_load_valid), 32'h0);
        step();
        check("to_buserr_one_cycle", 32'(w_buserr), 32'h0);

        // Reset two cycles into WAIT
        m_valid  = 1'b1;
        m_load   = 1'b1;
        m_addr   = 32'h0000_0080;
        m_loadop = 4'b0000;
        step();
        step();
        check("rw_req_before_reset", 32'(bus_if.bus_req), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rw_req_async_drop", 32'(bus_if.bus_req), 32'h0);
        check("rw_addr_async_clear", bus_if.bus_addr, 32'h0);
        idle_inputs();
        step();
        #2 reset = 1'b1;
        step();

        do_access(1'b1, 32'h0000_0100, 32'h0, 4'b0000, 4'b0000, 1, 32'h1234_5678,
                  stalls, s_we, s_addr, s_byteen, s_wdata);
        check("rw_lw_stall_cycles", 32'(stalls), 32'd2);
        check("rw_lw_bus_addr", s_addr, 32'h0000_0100);
        check("rw_lw_bus_byteen", 32'(s_byteen), 32'hF);
        check("rw_lw_w_rdata", w_rdata, 32'h1234_5678);
        check("rw_lw_load_valid", 32'(w_load_valid), 32'h1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
